// File: rtl/encoder_pkg.sv
// Shared definitions for the absolute-encoder read sequencer: FSM state
// encoding and the frame/position field layout the register map relies on.
package encoder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        ACK    = 3'd2,
        SHIFT  = 3'd3,
        MONO   = 3'd4
    } state_t;

    localparam int ENC_FRAME_BITS = 24;
    localparam int ENC_POS_MSB    = 21;
    localparam int ENC_POS_LSB    = 3;
    localparam int ENC_POS_W      = ENC_POS_MSB - ENC_POS_LSB + 1;

    // Larger of two counts; sizes a counter shared between two phases.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/encoder_sck_gen.sv
// Encoder clock generator. While enabled it produces sck periods of
// 2*CLK_DIV clocks, low half first; when disabled sck is forced high and the
// phase restarts so the next enable begins with a fresh low half.
// Valid/ready does not apply here: o_sample_strobe and o_period_done are
// single-cycle pulses on the last clock of each sck-high half.
module encoder_sck_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_sample_strobe,
    output logic o_period_done
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_half_cnt;
    logic          r_phase;      // 0 = low half, 1 = high half
    logic          w_half_end;

    assign w_half_end = (r_half_cnt == CW'(CLK_DIV - 1));

    // Half-period counter and phase toggle; held at the start of a low half while disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (!i_en) begin
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (w_half_end) begin
            r_half_cnt <= '0;
            r_phase    <= ~r_phase;
        end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
        end
    end

    assign o_sck           = i_en ? r_phase : 1'b1;
    assign o_sample_strobe = i_en & r_phase & w_half_end;
    assign o_period_done   = i_en & r_phase & w_half_end;

endmodule

// File: rtl/encoder_poll_ctrl.sv
// Master-side sequencer for the 24-bit SSI absolute encoder. Frames a read on
// a poll tick or a trigger, waits for the start bit, shifts the frame in, then
// holds cs_n/sck high for the monoflop recovery gap.
// Handshake: frame_valid stays high with frame_data/position stable until a
// cycle with frame_valid & frame_ready; a frame completing in that same cycle
// replaces the data and keeps frame_valid high without flagging overrun.
module encoder_poll_ctrl
    import encoder_pkg::*;
#(
    parameter int CLK_DIV      = 25,
    parameter int FRAME_BITS   = ENC_FRAME_BITS,
    parameter int POS_MSB      = ENC_POS_MSB,
    parameter int POS_LSB      = ENC_POS_LSB,
    parameter int ACK_TIMEOUT  = 32,
    parameter int MONOFLOP_CYC = 2000,
    parameter int POLL_PERIOD  = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       poll_en,
    input  logic                       trigger,
    output logic                       sck,
    output logic                       cs_n,
    input  logic                       miso,
    output logic [FRAME_BITS-1:0]      frame_data,
    output logic [POS_MSB-POS_LSB:0]   position,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic                       overrun,
    output logic                       timeout_err,
    output logic                       busy,
    output state_t                     o_dbg_state
);

    localparam int MCW = $clog2(max_int(MONOFLOP_CYC, CLK_DIV));
    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam int TCW = $clog2(ACK_TIMEOUT + 1);
    localparam int PCW = $clog2(POLL_PERIOD);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_miso_s1;
    logic                  r_miso_s2;
    logic [MCW-1:0]        r_tmr;
    logic [TCW-1:0]        r_to_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic [FRAME_BITS-2:0] r_sr;
    logic [PCW-1:0]        r_poll_cnt;
    logic [FRAME_BITS-1:0] r_frame_data;
    logic                  r_frame_valid;
    logic                  r_overrun;
    logic                  r_timeout_err;

    logic                  w_sck_en;
    logic                  w_sck;
    logic                  w_sample;
    logic                  w_period_done;
    logic                  w_poll_tick;
    logic                  w_frame_done;
    logic                  w_ack_fail;
    logic [FRAME_BITS-1:0] w_frame_new;

    assign w_sck_en    = (r_state == ACK) || (r_state == SHIFT);
    assign w_poll_tick = poll_en && (r_poll_cnt == PCW'(POLL_PERIOD - 1));
    assign w_frame_new = {r_sr, r_miso_s2};

    encoder_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_en            (w_sck_en),
        .o_sck           (w_sck),
        .o_sample_strobe (w_sample),
        .o_period_done   (w_period_done)
    );

    // Two-flop synchroniser for the asynchronous encoder data line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso_s1 <= 1'b1;
            r_miso_s2 <= 1'b1;
        end else begin
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    // Poll interval counter: runs only while polling is enabled, wraps each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poll_cnt <= '0;
        end else if (!poll_en || w_poll_tick) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and frame completion / start-bit timeout decode.
    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        w_ack_fail   = 1'b0;
        case (r_state)
            IDLE: begin
                if (trigger || w_poll_tick) w_state_next = SELECT;
            end
            SELECT: begin
                if (r_tmr == MCW'(CLK_DIV - 1)) w_state_next = ACK;
            end
            ACK: begin
                if (w_sample && !r_miso_s2) begin
                    w_state_next = SHIFT;
                end else if (w_period_done && (r_to_cnt == TCW'(ACK_TIMEOUT - 1))) begin
                    w_state_next = MONO;
                    w_ack_fail   = 1'b1;
                end
            end
            SHIFT: begin
                if (w_sample && (r_bit_cnt == BCW'(FRAME_BITS - 1))) begin
                    w_state_next = MONO;
                    w_frame_done = 1'b1;
                end
            end
            MONO: begin
                if (r_tmr == MCW'(MONOFLOP_CYC - 1)) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Phase timer for the select half-period and the monoflop gap; zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
        end else if (((r_state == SELECT) || (r_state == MONO)) && (w_state_next == r_state)) begin
            r_tmr <= r_tmr + 1'b1;
        end else begin
            r_tmr <= '0;
        end
    end

    // Start-bit wait counter: sck periods spent in ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != ACK) begin
            r_to_cnt <= '0;
        end else if (w_period_done) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Bit counter and shift register, MSB first, one bit per sample strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_sr      <= '0;
        end else if (r_state != SHIFT) begin
            r_bit_cnt <= '0;
        end else if (w_sample) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_sr      <= {r_sr[FRAME_BITS-3:0], r_miso_s2};
        end
    end

    // Output hold registers and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_frame_data  <= w_frame_new;
                r_frame_valid <= 1'b1;
                r_overrun     <= r_frame_valid & ~frame_ready;
                r_timeout_err <= 1'b0;
            end else if (r_frame_valid && frame_ready) begin
                r_frame_valid <= 1'b0;
                r_overrun     <= 1'b0;
            end
            if (w_ack_fail) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign sck         = w_sck;
    assign cs_n        = !((r_state == SELECT) || (r_state == ACK) || (r_state == SHIFT));
    assign busy        = (r_state != IDLE);
    assign frame_data  = r_frame_data;
    assign position    = r_frame_data[POS_MSB:POS_LSB];
    assign frame_valid = r_frame_valid;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign o_dbg_state = r_state;

endmodule
